des_key_schedule: RTL
=====================

# des_key_schedule

Sequential DES key schedule that expands one 64-bit key into the sixteen 48-bit round keys, in either encrypt order (K1..K16) or decrypt order (K16..K1). It sits directly upstream of the Feistel round function and drives its `round_key` input, one subkey per accepted handshake. It applies PC-1 once when the key is accepted, performs per-round C/D rotations in registers, and applies PC-2 as output wiring.

## Interface
- No parameters. DES geometry is fixed: 64-bit key, 16 rounds, 48-bit subkeys.
- `clk`  in  1  — single clock; all state is on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `key_i`  in  64  — DES key. Bit 63 is DES bit 1. Parity bits (DES bits 8, 16, …, 64) are ignored.
- `decrypt_i`  in  1  — 0 selects encrypt order, 1 selects decrypt order. Sampled only on key acceptance.
- `key_valid_i`  in  1  — a key is offered.
- `key_ready_o`  out  1  — the block can accept a key.
- `round_key_o`  out  48  — current subkey. Bit 47 is PC-2 output bit 1.
- `round_num_o`  out  4  — output sequence index, 0..15, counting up in both directions.
- `round_valid_o`  out  1  — `round_key_o` is valid.
- `round_ready_i`  in  1  — the consumer takes the subkey.
- `done_o`  out  1  — one-cycle pulse after the 16th subkey is taken.

## Operation
- **States:** IDLE and GEN.
- **Registers:** C[27:0], D[27:0], round counter [3:0], direction flag, `done_o`.
- **IDLE:**
  - `key_ready_o`=1 (forced 0 while `rst` is high); `round_valid_o`=0.
  - Acceptance happens when `key_valid_i` && `key_ready_o`.
  - On acceptance: latch `decrypt_i`, compute {C0,D0}=PC-1(`key_i`), counter←0, go to GEN.
  - Encrypt loads C←rotl(C0,1), D←rotl(D0,1), i.e. C1/D1.
  - Decrypt loads C←C0, D←D0, which equal C16/D16 because the total rotation is 28.
- **GEN:**
  - `round_valid_o`=1, `key_ready_o`=0, `round_key_o`=PC-2(C,D) (pure wiring), `round_num_o`=counter.
  - A handshake is `round_valid_o` && `round_ready_i`.
  - On a handshake with counter<15: counter+1, and C/D rotate by the amount for the next output:
    - Encrypt: rotl by s[counter+1], where s[0..15]=1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    - Decrypt: rotr by s[15−counter], giving the sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - On a handshake with counter==15: go to IDLE and set `done_o`=1 for the next cycle only.
- **Stalls:** while `round_valid_o` && !`round_ready_i`, `round_key_o`, `round_num_o` and the internal state hold exactly.
- **Busy:** `key_valid_i` and `decrypt_i` are ignored while in GEN.
- **Rotations:** 28-bit circular, applied independently to C and D. No arithmetic beyond the 4-bit counter, which never wraps inside GEN.

## Timing
- **Reset values:** state=IDLE, C=D=0, counter=0.
  - Outputs under reset: `round_valid_o`=0, `round_num_o`=0, `done_o`=0, `round_key_o`=PC-2(0)=0, `key_ready_o`=0 while `rst`=1 and 1 from the first cycle after deassertion.
- **Latency:** key accepted in cycle N gives `round_valid_o`=1 with index 0 in cycle N+1.
- **Throughput:** with `round_ready_i` held high, subkeys appear in N+1..N+16 and `done_o` pulses in N+17.
- **Back-to-back keys:** `key_ready_o` is 1 in the `done_o` cycle. A new key accepted there produces its first subkey in N+18, with no bubble beyond that cycle.
- **Reset mid-GEN:** outputs return to reset values immediately (asynchronous). No `done_o` pulse; the key in flight is discarded.
- **Stall on the last key:** `done_o` is issued only after the index-15 handshake, never before.

## Test plan
- **Encrypt vector:** key 0x133457799BBCDFF1, `decrypt_i`=0, ready held high.
  - Required subkeys: index0 0x1B02EFFC7072, index1 0x79AED9DBC9E5, index15 0xCB3D8B0E17F5.
  - `done_o` in cycle N+17; all 16 subkeys match a reference model.
- **Decrypt vector:** same key, `decrypt_i`=1.
  - Required subkeys: index0 0xCB3D8B0E17F5, index14 0x79AED9DBC9E5, index15 0x1B02EFFC7072.
- **Parity invariance:** key 0x123556789ABDDEF0 gives subkeys identical to the encrypt vector.
- **Backpressure:** drop `round_ready_i` randomly, including a 5-cycle stall at index 7 and at index 15.
  - `round_key_o` and `round_num_o` stay stable during stalls; no index is skipped or duplicated; `done_o` fires exactly once, after the index-15 handshake.
  - `key_valid_i` pulsed during GEN is ignored.
- **Reset mid-GEN:** assert `rst` at index 9.
  - `round_valid_o` drops in the same cycle, `done_o` stays 0, `key_ready_o` returns to 1 after release.
  - The next key (decrypt vector) runs correctly from index 0.
- **Back-to-back:** encrypt key, then a decrypt key offered in the `done_o` cycle.
  - Accepted immediately; first decrypt subkey 0xCB3D8B0E17F5 appears 18 cycles after the first acceptance.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: expands one 64-bit key into sixteen 48-bit round keys,
// one per consumer handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
// PC-1 is applied once at key acceptance; C/D rotate in registers; PC-2 is wiring.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  output logic [47:0] round_key_o,
  output logic [3:0]  round_num_o,
  output logic        round_valid_o,
  input  logic        round_ready_i,
  output logic        done_o
);

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  // Entry i is the DES bit number feeding output bit i+1 (DES bit 1 = MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Rotation amount for schedule index idx: 1 at indices 0,1,8,15, else 2.
  function automatic logic shift_two(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic [55:0] cd0;
  logic        accept, hs, last;
  logic        unused_parity;

  assign cd0    = pc1(key_i);
  assign accept = key_valid_i && key_ready_o;
  assign hs     = round_valid_o && round_ready_i;
  assign last   = (cnt_q == 4'd15);

  // Parity bits of the key carry no key material.
  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8],  key_i[0]};

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  // Next state: IDLE -> GEN on key acceptance, GEN -> IDLE on the final handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = GEN;
      GEN:     if (hs && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load C/D from PC-1 on acceptance, rotate toward the next subkey on handshake.
  always_comb begin
    c_d    = c_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    dec_d  = dec_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        dec_d = decrypt_i;
        cnt_d = 4'd0;
        // Decrypt starts at C0/D0, which equals C16/D16 (total rotation is 28).
        if (decrypt_i) begin
          c_d = cd0[55:28];
          d_d = cd0[27:0];
        end else begin
          c_d = rotl(cd0[55:28], 1'b0);
          d_d = rotl(cd0[27:0], 1'b0);
        end
      end
    end else if (hs) begin
      if (last) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
        if (dec_q) begin
          c_d = rotr(c_q, shift_two(4'd15 - cnt_q));
          d_d = rotr(d_q, shift_two(4'd15 - cnt_q));
        end else begin
          c_d = rotl(c_q, shift_two(cnt_q + 4'd1));
          d_d = rotl(d_q, shift_two(cnt_q + 4'd1));
        end
      end
    end
  end

  // Outputs: handshake flags from state; subkey is PC-2 wiring of the C/D registers.
  always_comb begin
    key_ready_o   = (state_q == IDLE) && !rst;
    round_valid_o = (state_q == GEN);
    round_key_o   = pc2({c_q, d_q});
    round_num_o   = cnt_q;
    done_o        = done_q;
  end

endmodule
